// File: rtl/bcd_time_counter.sv
// Time-of-day counter: packed-BCD hours/minutes/seconds advanced by a clk prescaler,
// with a validated time-set load and single-cycle rollover strobes.
module bcd_time_counter #(
  parameter int unsigned TICKS_PER_SEC = 1000,
  parameter int unsigned PRESCALE_W    = 24
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       run_en,
  input  logic       set_en,
  input  logic [7:0] set_hour,
  input  logic [7:0] set_minute,
  input  logic [7:0] set_second,
  output logic [7:0] Hour,
  output logic [7:0] Minute,
  output logic [7:0] Second,
  output logic       sec_pulse,
  output logic       min_pulse,
  output logic       hour_pulse,
  output logic       set_err
);

  localparam logic [PRESCALE_W-1:0] TERM = PRESCALE_W'(TICKS_PER_SEC - 1);

  logic [PRESCALE_W-1:0] r_presc;
  logic                  w_tc;
  logic                  w_set_ok;
  logic                  w_sec_wrap;
  logic                  w_min_wrap;

  // Single BCD digit-pair increment; callers handle the decade/day wrap.
  function automatic logic [7:0] bcd_inc(input logic [7:0] v);
    if (v[3:0] == 4'd9) bcd_inc = {v[7:4] + 4'd1, 4'd0};
    else                bcd_inc = {v[7:4], v[3:0] + 4'd1};
  endfunction

  assign w_tc       = run_en && (r_presc == TERM);
  assign w_sec_wrap = (Second == 8'h59);
  assign w_min_wrap = (Minute == 8'h59);

  // Tens digits bounded first so the byte compare only has to reject e.g. 24..29.
  assign w_set_ok = (set_hour[7:4]   <= 4'd2) && (set_hour[3:0]   <= 4'd9) && (set_hour   <= 8'h23)
                 && (set_minute[7:4] <= 4'd5) && (set_minute[3:0] <= 4'd9)
                 && (set_second[7:4] <= 4'd5) && (set_second[3:0] <= 4'd9);

  always_ff @(posedge clk) begin
    if (rst) begin
      r_presc    <= '0;
      Hour       <= 8'h00;
      Minute     <= 8'h00;
      Second     <= 8'h00;
      sec_pulse  <= 1'b0;
      min_pulse  <= 1'b0;
      hour_pulse <= 1'b0;
      set_err    <= 1'b0;
    end else begin
      sec_pulse  <= 1'b0;
      min_pulse  <= 1'b0;
      hour_pulse <= 1'b0;
      set_err    <= 1'b0;
      if (set_en && w_set_ok) begin
        // A valid load pre-empts any coincident tick and restarts the second.
        r_presc <= '0;
        Hour    <= set_hour;
        Minute  <= set_minute;
        Second  <= set_second;
      end else begin
        set_err <= set_en;
        if (w_tc) begin
          r_presc   <= '0;
          sec_pulse <= 1'b1;
          if (w_sec_wrap) begin
            Second    <= 8'h00;
            min_pulse <= 1'b1;
            if (w_min_wrap) begin
              Minute     <= 8'h00;
              hour_pulse <= 1'b1;
              Hour       <= (Hour == 8'h23) ? 8'h00 : bcd_inc(Hour);
            end else begin
              Minute <= bcd_inc(Minute);
            end
          end else begin
            Second <= bcd_inc(Second);
          end
        end else if (run_en) begin
          r_presc <= r_presc + PRESCALE_W'(1);
        end
      end
    end
  end

endmodule

// File: tb/tb_bcd_time_counter.sv
// Bench for bcd_time_counter: seconds-of-day reference model, per-cycle compare,
// directed scenarios with literal expectations, then randomized traffic.
module tb_bcd_time_counter;

  localparam int unsigned TPS = 4;

  logic       clk = 1'b0;
  logic       rst, run_en, set_en;
  logic [7:0] set_hour, set_minute, set_second;
  logic [7:0] Hour, Minute, Second;
  logic       sec_pulse, min_pulse, hour_pulse, set_err;

  bcd_time_counter #(.TICKS_PER_SEC(TPS), .PRESCALE_W(3)) dut (
    .clk(clk), .rst(rst), .run_en(run_en), .set_en(set_en),
    .set_hour(set_hour), .set_minute(set_minute), .set_second(set_second),
    .Hour(Hour), .Minute(Minute), .Second(Second),
    .sec_pulse(sec_pulse), .min_pulse(min_pulse), .hour_pulse(hour_pulse),
    .set_err(set_err)
  );

  always #5 clk = ~clk;

  int n_vec = 0;
  int n_bad = 0;

  // Reference state: time as seconds since midnight plus a cycle count within the second.
  int m_tod = 0;
  int m_pre = 0;
  bit m_ok  = 1'b0;
  bit e_sec = 1'b0, e_min = 1'b0, e_hr = 1'b0, e_err = 1'b0;

  function automatic int dec(input logic [7:0] b);
    return int'(b[7:4]) * 10 + int'(b[3:0]);
  endfunction

  function automatic logic [7:0] to_bcd(input int n);
    return {4'(n / 10), 4'(n % 10)};
  endfunction

  function automatic bit legal(input logic [7:0] h, input logic [7:0] m, input logic [7:0] s);
    if (h[7:4] > 4'd9 || h[3:0] > 4'd9 || m[7:4] > 4'd9 || m[3:0] > 4'd9 ||
        s[7:4] > 4'd9 || s[3:0] > 4'd9) return 1'b0;
    return dec(h) < 24 && dec(m) < 60 && dec(s) < 60;
  endfunction

  always @(posedge clk) begin : model
    int nt, np;
    bit ps, pm, ph, pe;
    nt = m_tod; np = m_pre; ps = 0; pm = 0; ph = 0; pe = 0;
    if (rst) begin
      nt = 0; np = 0;
    end else if (set_en && legal(set_hour, set_minute, set_second)) begin
      nt = dec(set_hour) * 3600 + dec(set_minute) * 60 + dec(set_second);
      np = 0;
    end else begin
      pe = set_en;
      if (run_en) begin
        if (m_pre == TPS - 1) begin
          np = 0;
          nt = (m_tod + 1) % 86400;
          ps = 1;
          pm = (m_tod % 60) == 59;
          ph = (m_tod % 3600) == 3599;
        end else begin
          np = m_pre + 1;
        end
      end
    end
    m_tod <= nt; m_pre <= np;
    e_sec <= ps; e_min <= pm; e_hr <= ph; e_err <= pe;
    if (rst) m_ok <= 1'b1;
  end

  task automatic chk(input string nm, input logic [7:0] act, input logic [7:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s at %0t: got %h expected %h", nm, $time, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (m_ok) begin
      chk("Hour",       Hour,              to_bcd(m_tod / 3600));
      chk("Minute",     Minute,            to_bcd((m_tod / 60) % 60));
      chk("Second",     Second,            to_bcd(m_tod % 60));
      chk("sec_pulse",  8'(sec_pulse),     8'(e_sec));
      chk("min_pulse",  8'(min_pulse),     8'(e_min));
      chk("hour_pulse", 8'(hour_pulse),    8'(e_hr));
      chk("set_err",    8'(set_err),       8'(e_err));
    end
  end

  task automatic step(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic do_set(input logic [7:0] h, input logic [7:0] m, input logic [7:0] s);
    set_en = 1'b1; set_hour = h; set_minute = m; set_second = s;
    step(1);
    set_en = 1'b0;
  endtask

  task automatic lit_time(input string tag, input logic [7:0] h, input logic [7:0] m,
                          input logic [7:0] s);
    chk({tag, ".H"}, Hour, h);
    chk({tag, ".M"}, Minute, m);
    chk({tag, ".S"}, Second, s);
  endtask

  initial begin
    rst = 1'b1; run_en = 1'b0; set_en = 1'b0;
    set_hour = 8'h00; set_minute = 8'h00; set_second = 8'h00;
    step(2);
    lit_time("reset", 8'h00, 8'h00, 8'h00);

    // 1: free run, first tick four cycles after release
    rst = 1'b0; run_en = 1'b1;
    step(3);
    chk("t1.no_early_tick", 8'(sec_pulse), 8'h0);
    step(13);
    chk("t1.sec", Second, 8'h04);
    chk("t1.pulse", 8'(sec_pulse), 8'h1);

    // 2: carry through minutes into hour tens
    do_set(8'h09, 8'h59, 8'h58);
    chk("t2.load_nopulse", 8'(sec_pulse), 8'h0);
    step(4);
    lit_time("t2a", 8'h09, 8'h59, 8'h59);
    step(4);
    lit_time("t2b", 8'h10, 8'h00, 8'h00);
    chk("t2.pulses", {5'd0, hour_pulse, min_pulse, sec_pulse}, 8'h07);

    // 3: end-of-day wrap
    do_set(8'h23, 8'h59, 8'h59);
    step(4);
    lit_time("t3", 8'h00, 8'h00, 8'h00);
    chk("t3.pulses", {5'd0, hour_pulse, min_pulse, sec_pulse}, 8'h07);

    // 4: rejected loads, frozen so time is provably unchanged
    run_en = 1'b0;
    do_set(8'h24, 8'h00, 8'h00); chk("t4.err24", 8'(set_err), 8'h1);
    do_set(8'h1A, 8'h00, 8'h00); chk("t4.err1A", 8'(set_err), 8'h1);
    do_set(8'h00, 8'h60, 8'h00); chk("t4.err60", 8'(set_err), 8'h1);
    lit_time("t4.hold", 8'h00, 8'h00, 8'h00);
    do_set(8'h19, 8'h00, 8'h00);
    chk("t4.ok", 8'(set_err), 8'h0);
    lit_time("t4.load", 8'h19, 8'h00, 8'h00);

    // 5: load on the terminal-count cycle
    run_en = 1'b1;
    step(3);
    do_set(8'h12, 8'h34, 8'h56);
    lit_time("t5", 8'h12, 8'h34, 8'h56);
    chk("t5.nopulse", 8'(sec_pulse), 8'h0);
    step(3);
    chk("t5.notyet", 8'(sec_pulse), 8'h0);
    step(1);
    chk("t5.tick", Second, 8'h57);

    // 6: freeze mid-second, then reset mid-run
    step(2);
    run_en = 1'b0;
    step(10);
    chk("t6.frozen", Second, 8'h57);
    run_en = 1'b1;
    step(2);
    chk("t6.resume", Second, 8'h58);
    step(1);
    rst = 1'b1;
    step(1);
    lit_time("t6.rst", 8'h00, 8'h00, 8'h00);
    rst = 1'b0;
    step(3);
    chk("t6.notick", 8'(sec_pulse), 8'h0);
    step(1);
    chk("t6.tick", Second, 8'h01);

    // Randomized traffic; legal loads biased near rollover points
    for (int i = 0; i < 3000; i++) begin
      rst    = ($urandom_range(0, 199) == 0);
      run_en = ($urandom_range(0, 9) != 0);
      set_en = ($urandom_range(0, 19) == 0);
      if ($urandom_range(0, 1) == 0) begin
        set_hour   = to_bcd($urandom_range(0, 1) ? 23 : int'($urandom_range(0, 23)));
        set_minute = to_bcd($urandom_range(0, 1) ? 59 : int'($urandom_range(0, 59)));
        set_second = to_bcd(int'($urandom_range(55, 59)));
      end else begin
        set_hour   = 8'($urandom);
        set_minute = 8'($urandom);
        set_second = 8'($urandom);
      end
      step(1);
    end
    rst = 1'b0; set_en = 1'b0;
    step(2);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule

// File: doc/bcd_time_counter.md
Name: bcd_time_counter

Overview:
- Time-of-day source for the digital clock: keeps hours, minutes and seconds as packed BCD.
- Drives the Hour/Minute buses that the hourly chime and display logic read.
- Divides the system clock down to a 1 Hz advance, cascades BCD carries and accepts a validated time-set load.
- Emits single-cycle rollover strobes for downstream consumers.

Parameters:
- TICKS_PER_SEC, 1000: clk cycles per second. Legal range 2..2^24. Benches use 4.
- PRESCALE_W, 24: width of the prescaler counter. Must satisfy 2^PRESCALE_W >= TICKS_PER_SEC.

Ports:
- clk  in  1  system clock; all logic on the rising edge.
- rst  in  1  synchronous, active-high reset.
- run_en  in  1  1 = time advances; 0 = freeze (prescaler holds).
- set_en  in  1  one-cycle request to load set_hour/set_minute/set_second.
- set_hour  in  8  BCD hour, 00..23.
- set_minute  in  8  BCD minute, 00..59.
- set_second  in  8  BCD second, 00..59.
- Hour  out  8  BCD hour, [7:4] tens, [3:0] units.
- Minute  out  8  BCD minute.
- Second  out  8  BCD second.
- sec_pulse  out  1  one-cycle strobe when Second advances.
- min_pulse  out  1  one-cycle strobe when Minute advances.
- hour_pulse  out  1  one-cycle strobe when Hour advances.
- set_err  out  1  one-cycle strobe when a set request is rejected.

Behaviour:
- Clock and reset: one clock, clk. Reset is synchronous and active-high on rst.
- Reset (rst=1 at a rising edge):
  - Hour, Minute, Second = 8'h00; prescaler = 0.
  - All pulse outputs and set_err = 0.
  - rst overrides set_en and run_en in the same cycle. Reset mid-count discards the partial second.
- All outputs are registered. Pulses are high in exactly the cycle the new time value is first visible.
- Prescaler:
  - When run_en=1, it counts 0..TICKS_PER_SEC-1.
  - At terminal count it wraps to 0 and a tick occurs on that edge.
  - When run_en=0, the prescaler and time hold and no pulses are generated.
- Tick (BCD cascade):
  - Second units 9 -> 0 with tens+1; Second 59 -> 00 and carries to Minute.
  - Minute follows the same rule and carries to Hour.
  - Hour: units 9 -> 0 with tens+1; 23 -> 00.
  - sec_pulse=1 on every tick; min_pulse=1 when Second wraps; hour_pulse=1 when Minute wraps.
  - 23:59:59 -> 00:00:00 asserts all three pulses in the same cycle.
- Set request (set_en=1) is valid only when all of these hold:
  - every nibble is <= 9;
  - set_hour <= 8'h23;
  - set_minute <= 8'h59;
  - set_second <= 8'h59.
- Valid set:
  - Values load on that edge; prescaler clears to 0; no sec/min/hour pulse.
  - The next tick occurs TICKS_PER_SEC cycles later (with run_en=1).
- Invalid set: time and prescaler behave as if set_en=0 (a tick may still occur), and set_err=1 for one cycle.
- Simultaneous valid set and prescaler terminal count: the set wins, the tick is discarded, no pulses.
- set_en held high for N cycles reloads the same value every cycle. The prescaler stays 0 and no ticks occur.
- Set is accepted regardless of run_en.
- No illegal BCD values can ever appear on Hour, Minute or Second.

Test Plan (TICKS_PER_SEC=4):
1. Reset then run_en=1 for 16 cycles -> Second = 8'h04. sec_pulse high every 4th cycle, first at cycle 4 after reset release. min_pulse and hour_pulse stay 0.
2. Valid set 8'h09/8'h59/8'h58, then run 8 cycles -> 09:59:59, then 10:00:00. At the second tick sec_pulse, min_pulse and hour_pulse are all 1 in one cycle.
3. Valid set 23:59:59, then 1 tick -> 00:00:00 with all three pulses. Checks the Hour units 3 -> 0 wrap at tens=2.
4. set_en with set_hour = 8'h24, then 8'h1A, then set_minute = 8'h60 -> set_err pulses each time and time is unchanged. The valid value 8'h19/8'h00/8'h00 then loads with no set_err.
5. Assert set_en exactly on a prescaler terminal-count cycle -> the loaded value is shown with no sec_pulse. The next tick comes 4 cycles later.
6. run_en=0 for 10 cycles mid-second -> time and prescaler frozen, no pulses. rst mid-run -> 00:00:00 on the next edge, pulses 0, and the first tick 4 cycles after release.
